constraint_mem_ctrl: RTL

// Owns the single-port constraint BRAM between the byte-stream parser and the line solver.

---
 rtl/constraint_mem_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/constraint_mem_ctrl.sv
// constraint_mem_ctrl
// Sole owner of the single-port constraint BRAM sitting between the byte-stream
// parser and the line solver.
//   LOAD : parser words are committed to consecutive BRAM addresses.
//   SERVE: entered on board_done; the solver gets one pipelined read per cycle.
//   clear: drops the current board and returns to LOAD from any state.
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   wr_valid/wr_data  parser word stream
//   board_done        parser finished the board (pulse)
//   clear             discard board, restart load (pulse)
//   rd_req/rd_addr    solver read request; rd_gnt is the combinational accept
//   rd_valid/rd_data  read response, RD_LAT cycles after grant (0 if out of range)
//   loaded            high in SERVE
//   num_entries       words committed for the current board (saturates at DEPTH)
//   err               sticky: overflow or write attempt during SERVE
//   bram_*            BRAM port; bram_dout arrives RD_LAT cycles after the address
module constraint_mem_ctrl #(
  parameter int DATA_W = 13,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              board_done,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              loaded,
  output logic [ADDR_W:0]   num_entries,
  output logic              err,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {LOAD, SERVE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   wr_ptr;
  logic [RD_LAT-1:0] tag_pipe;
  logic [RD_LAT-1:0] oor_pipe;
  logic              wr_ok;
  logic              wr_drop;
  logic              rd_oor;

  // Out-of-range is decided at grant time and travels with the grant tag.
  assign rd_oor = ({1'b0, rd_addr} >= wr_ptr);

  always_comb begin
    state_nx  = state;
    bram_addr = '0;
    bram_din  = '0;
    bram_we   = 1'b0;
    rd_gnt    = 1'b0;
    wr_ok     = 1'b0;
    wr_drop   = 1'b0;
    if (clear) begin
      state_nx = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (wr_valid) begin
            if (wr_ptr < DEPTH_L) wr_ok   = 1'b1;
            else                  wr_drop = 1'b1;
          end
          if (board_done) state_nx = SERVE;
        end
        SERVE: begin
          if (wr_valid) wr_drop = 1'b1;
        end
        default: state_nx = LOAD;
      endcase
    end
    if (state == SERVE) begin
      rd_gnt = rd_req;
      if (rd_req) bram_addr = rd_addr;
    end
    if (wr_ok) begin
      bram_we   = 1'b1;
      bram_addr = wr_ptr[ADDR_W-1:0];
      bram_din  = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD;
      wr_ptr   <= '0;
      err      <= 1'b0;
      tag_pipe <= '0;
      oor_pipe <= '0;
    end else begin
      state <= state_nx;
      if (clear)      wr_ptr <= '0;
      else if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (wr_drop) err <= 1'b1;
      if (clear) begin
        tag_pipe <= '0;
        oor_pipe <= '0;
      end else begin
        tag_pipe[0] <= rd_gnt;
        oor_pipe[0] <= rd_gnt & rd_oor;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
          tag_pipe[i] <= tag_pipe[i-1];
          oor_pipe[i] <= oor_pipe[i-1];
        end
      end
    end
  end

  assign loaded      = (state == SERVE);
  assign num_entries = wr_ptr;
  assign rd_valid    = tag_pipe[RD_LAT-1];
  assign rd_data     = (rd_valid && !oor_pipe[RD_LAT-1]) ? bram_dout : '0;

endmodule
